// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one word read in flight and queues returned words with their PCs for the core.
// Define FETCH_STATS_EN to add the saturating stat_fetched / stat_flushed counters.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [31:0]           mem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           stat_fetched,
    output logic [31:0]           stat_flushed
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, r_req_pc;
    logic [31:0]           r_data [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc   [DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_req_fire, w_push, w_pop;
    logic [ADDR_WIDTH-1:0] w_redir_pc;

    // r_run keeps the request channel quiet while reset is held and for the first edge after release.
    assign mem_req_valid = r_run && (r_state == S_IDLE) && (r_count < CW'(DEPTH));
    assign mem_req_addr  = r_fetch_pc;
    assign instr_valid   = (r_count != '0);
    assign instr_data    = instr_valid ? r_data[r_rptr] : '0;
    assign instr_pc      = instr_valid ? r_pc[r_rptr]   : '0;

    assign w_req_fire = mem_req_valid && mem_req_ready;
    assign w_push     = (r_state == S_WAIT) && mem_resp_valid && !redirect_valid;
    assign w_pop      = instr_valid && instr_ready;
    assign w_redir_pc = redirect_pc & ~ADDR_WIDTH'(3);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_fire)     w_state_nxt = S_WAIT;
            S_WAIT:  if (mem_resp_valid) w_state_nxt = S_IDLE;
            S_DROP:  if (mem_resp_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Anything still owed by memory at a redirect must be swallowed, not queued.
        if (redirect_valid && (w_state_nxt == S_WAIT)) w_state_nxt = S_DROP;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
        end else begin
            r_run <= 1'b1;
            if (w_req_fire) r_req_pc <= r_fetch_pc;
            if (redirect_valid)  r_fetch_pc <= w_redir_pc;
            else if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wptr] <= mem_resp_data;
            r_pc[r_wptr]   <= r_req_pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetched, r_flushed;
    logic        w_inflight;
    logic [32:0] w_fl_sum;

    // A request accepted in the redirect cycle is already owed by memory, so it counts as flushed too.
    assign w_inflight = (r_state == S_WAIT) || w_req_fire;
    assign w_fl_sum   = {1'b0, r_flushed} + 33'(r_count) - 33'(w_pop) + 33'(w_inflight);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetched <= '0;
            r_flushed <= '0;
        end else begin
            if (w_push && (r_fetched != '1)) r_fetched <= r_fetched + 32'd1;
            if (redirect_valid) r_flushed <= w_fl_sum[32] ? '1 : w_fl_sum[31:0];
        end
    end

    assign stat_fetched = r_fetched;
    assign stat_flushed = r_flushed;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural memory answers fetches, directed phases
// queue the expected {pc, data} stream and a monitor checks every instruction the core consumes.
module tb_instr_fetch_unit;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_flushed;
`endif

    always #5 clock = ~clock;

    instr_fetch_unit dut (
        .clock(clock), .reset_n(reset_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_q[$];
    int          n_vec = 0, n_err = 0, n_pop = 0, n_req = 0;
    int          lat = 1;
    bit          hold = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    // Memory: word at address A reads as {16'hC0DE, A[15:0]}, returned lat cycles after acceptance.
    always begin
        @(negedge clock);
        if (reset_n && mem_req_valid && mem_req_ready) begin
            pend      = 1'b1;
            pend_cnt  = lat;
            pend_addr = mem_req_addr;
        end
        @(posedge clock);
        #1;
        mem_resp_valid = 1'b0;
        if (pend) begin
            if (pend_cnt > 1) pend_cnt--;
            else if (!hold) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = {16'hC0DE, pend_addr[15:0]};
                pend           = 1'b0;
            end
        end
    end

    // Monitor: log accepted requests and check each consumed instruction against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && mem_req_valid && mem_req_ready) begin
            n_req++;
            req_q.push_back(mem_req_addr);
        end
        if (reset_n && instr_valid && instr_ready) begin
            n_pop++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_instr: got pc=%08h data=%08h, nothing expected", instr_pc, instr_data);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instr_data !== e.data) begin
                    n_err++;
                    $display("FAIL instr_stream: got pc=%08h data=%08h, want pc=%08h data=%08h",
                             instr_pc, instr_data, e.pc, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] pc;
            pc = base + 32'(4 * i);
            exp_q.push_back({pc, 16'hC0DE, pc[15:0]});
        end
    endtask

    task automatic wait_pops(input int n, input int budget);
        int c = 0;
        while (n_pop < n && c < budget) begin tick(); c++; end
        if (n_pop < n) begin
            n_vec++; n_err++;
            $display("FAIL timeout_pops: got %0d want %0d", n_pop, n);
        end
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int c = 0;
        while (n_req < n && c < budget) begin tick(); c++; end
        if (n_req < n) begin
            n_vec++; n_err++;
            $display("FAIL timeout_reqs: got %0d want %0d", n_req, n);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        mem_req_ready = 1'b1; hold = 1'b0; lat = 1; pend = 1'b0;
        repeat (3) tick();
        exp_q.delete(); req_q.delete();
        n_pop = 0; n_req = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) tick();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr",  mem_req_addr,  0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data",  instr_data,  0);
        chk("rst_instr_pc",    instr_pc,    0);

        // Streaming: ten instructions in order.
        do_reset();
        instr_ready = 1'b1;
        expect_seq(32'h0, 10);
        wait_pops(10, 200);
        instr_ready = 1'b0;

        // Core stall fills the FIFO, then drains and fetch resumes at 0x10.
        do_reset();
        repeat (20) tick();
        chk("stall_reqs", n_req, 4);
        chk("stall_req_valid", mem_req_valid, 0);
        chk("stall_fetch_pc", mem_req_addr, 32'h10);
        chk("stall_head_pc", instr_pc, 32'h0);
        expect_seq(32'h0, 8);
        instr_ready = 1'b1;
        wait_pops(8, 200);
        instr_ready = 1'b0;
        chk("resume_addr", (req_q.size() > 4) ? req_q[4] : 32'hDEAD_BEEF, 32'h10);

        // Redirect with a request outstanding and two words queued.
        do_reset();
        lat = 3;
        wait_reqs(3, 100);
        chk("pre_redirect_head", instr_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 32'h103; req_q.delete();
        tick();
        redirect_valid = 1'b0;
        chk("redirect_flush", instr_valid, 0);
        expect_seq(32'h100, 3);
        instr_ready = 1'b1;
        wait_pops(3, 200);
        instr_ready = 1'b0;
        chk("redirect_addr", (req_q.size() > 0) ? req_q[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect in the same cycle as the response.
        do_reset();
        hold = 1'b1;
        wait_reqs(1, 50);
        repeat (2) tick();
        @(negedge clock);
        hold = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200; req_q.delete();
        tick();
        redirect_valid = 1'b0;
        chk("coincide_drop", instr_valid, 0);
        expect_seq(32'h200, 2);
        instr_ready = 1'b1;
        wait_pops(2, 100);
        instr_ready = 1'b0;
        chk("coincide_addr", (req_q.size() > 0) ? req_q[0] : 32'hDEAD_BEEF, 32'h200);

        // Memory back-pressure: address held, then one acceptance advances the PC.
        do_reset();
        mem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_req_valid", mem_req_valid, 1);
            chk("bp_req_addr", mem_req_addr, 32'h0);
        end
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("bp_fetch_pc", mem_req_addr, 32'h4);
        chk("bp_reqs", n_req, 1);
        expect_seq(32'h0, 1);
        instr_ready = 1'b1;
        wait_pops(1, 50);
        instr_ready = 1'b0;

`ifdef FETCH_STATS_EN
        // Fill 4, pop 1, hold the refill in flight, redirect: 3 queued + 1 in flight flushed.
        do_reset();
        repeat (20) tick();
        hold = 1'b1;
        expect_seq(32'h0, 1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("stat_fetched", stat_fetched, 4);
        chk("stat_flushed", stat_flushed, 4);
        hold = 1'b0;
        repeat (3) tick();
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
